serial_chunk_subtractor: RTL and testbench

SERIAL_CHUNK_SUBTRACTOR -- requirements
Module: serial_chunk_subtractor

---
 rtl/serial_chunk_subtractor_if.sv | 26 ++
 rtl/serial_chunk_subtractor.sv | 107 ++++++++++
 tb/tb_serial_chunk_subtractor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serial_chunk_subtractor_if.sv
// Handshake and data bundle for serial_chunk_subtractor.
// The overflow signal is present only when SUB_OVERFLOW_EN is defined.
interface serial_chunk_subtractor_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SUB_OVERFLOW_EN
  logic             overflow;

  modport master (output in_valid, a, b, borrow_in, out_ready,
                  input  in_ready, out_valid, diff, borrow_out, overflow);
  modport slave  (input  in_valid, a, b, borrow_in, out_ready,
                  output in_ready, out_valid, diff, borrow_out, overflow);
`else
  modport master (output in_valid, a, b, borrow_in, out_ready,
                  input  in_ready, out_valid, diff, borrow_out);
  modport slave  (input  in_valid, a, b, borrow_in, out_ready,
                  output in_ready, out_valid, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_chunk_subtractor.sv
// Serial subtractor: computes a - b - borrow_in one CHUNK-bit slice per cycle,
// least-significant chunk first, rippling the borrow through a register.
// Optional macro SUB_OVERFLOW_EN adds a signed-overflow output.
// WIDTH must be a multiple of CHUNK, CHUNK >= 1.
module serial_chunk_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_chunk_subtractor_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Operands captured at acceptance; the bus may change freely afterwards.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  state_t           state, state_nxt;
  opnd_t            opnd;
  logic [CW-1:0]    idx;
  logic             brw;
  logic [WIDTH-1:0] diff_q;
  logic             bo_q;
  logic [CHUNK:0]   res;
  logic             last;
  logic             accept;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q;
`endif

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (idx == CW'(N - 1));

  // One chunk of the subtraction; the extra MSB is the borrow out of the chunk.
  always_comb begin
    res = {1'b0, opnd.a[int'(idx)*CHUNK +: CHUNK]}
        - {1'b0, opnd.b[int'(idx)*CHUNK +: CHUNK]}
        - {{CHUNK{1'b0}}, brw};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = BUSY;
      BUSY:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, then fill diff one chunk per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd   <= '0;
      idx    <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bo_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      opnd   <= '{a: bus.a, b: bus.b};
      brw    <= bus.borrow_in;
      idx    <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else if (state == BUSY) begin
      diff_q[int'(idx)*CHUNK +: CHUNK] <= res[CHUNK-1:0];
      brw <= res[CHUNK];
      idx <= last ? '0 : idx + CW'(1);
      if (last) begin
        bo_q  <= res[CHUNK];
`ifdef SUB_OVERFLOW_EN
        // res[CHUNK-1] is the final sign bit of diff.
        ovf_q <= (opnd.a[WIDTH-1] != opnd.b[WIDTH-1]) &&
                 (res[CHUNK-1]    != opnd.a[WIDTH-1]);
`endif
      end
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_chunk_subtractor.sv
// Directed bench for serial_chunk_subtractor at WIDTH=32, CHUNK=8.
module tb_serial_chunk_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_chunk_subtractor_if #(.WIDTH(32)) sif ();

  serial_chunk_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid, counting edges since acceptance (k starts at the count given).
  task automatic wait_done(inout int k);
    while (!sif.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbi,
                       input logic [31:0] ed, input logic eb, input logic eo,
                       input string tag);
    int k;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'b0, sif.in_ready}, 32'd1);
    sif.a = ta; sif.b = tb_; sif.borrow_in = tbi; sif.in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble the bus: the result must come from the captured operands.
    sif.in_valid = 1'b0; sif.a = ~ta; sif.b = 32'h5A5A_5A5A; sif.borrow_in = ~tbi;
    k = 0;
    wait_done(k);
    chk({tag, " latency"}, k, 32'd4);
    chk({tag, " diff"}, sif.diff, ed);
    chk({tag, " borrow_out"}, {31'b0, sif.borrow_out}, {31'b0, eb});
`ifdef SUB_OVERFLOW_EN
    chk({tag, " overflow"}, {31'b0, sif.overflow}, {31'b0, eo});
`else
    if (eo) ;
`endif
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.out_ready = 1'b0;
    chk({tag, " out_valid drop"}, {31'b0, sif.out_valid}, 32'd0);
    chk({tag, " in_ready back"}, {31'b0, sif.in_ready}, 32'd1);
  endtask

  initial begin
    int k;
    sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.borrow_in = 1'b0; sif.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst in_ready",   {31'b0, sif.in_ready},   32'd1);
    chk("rst out_valid",  {31'b0, sif.out_valid},  32'd0);
    chk("rst diff",       sif.diff,                32'd0);
    chk("rst borrow_out", {31'b0, sif.borrow_out}, 32'd0);
`ifdef SUB_OVERFLOW_EN
    chk("rst overflow",   {31'b0, sif.overflow},   32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Basic and boundary vectors
    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, "5-3");
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "0-1");
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, "min-1");
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "eq-bin");
    do_op(32'h0000_FF00, 32'h0000_00FF, 1'b0, 32'h0000_FE01, 1'b0, 1'b0, "mid");
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, "max-neg1");

    // out_ready already high when DONE is reached: one-cycle DONE
    @(negedge clk);
    sif.a = 32'h0000_0100; sif.b = 32'h0000_0001; sif.borrow_in = 1'b1; sif.in_valid = 1'b1;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    k = 0;
    wait_done(k);
    chk("early latency", k, 32'd4);
    chk("early diff", sif.diff, 32'h0000_00FE);
    @(posedge clk); #1;
    chk("early out_valid drop", {31'b0, sif.out_valid}, 32'd0);
    sif.out_ready = 1'b0;

    // Back-pressure in DONE and in_valid pulsed during BUSY
    @(negedge clk);
    sif.a = 32'h000A_0000; sif.b = 32'h0000_0001; sif.borrow_in = 1'b0; sif.in_valid = 1'b1;
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    @(negedge clk);
    chk("busy in_ready", {31'b0, sif.in_ready}, 32'd0);
    sif.a = 32'h1111_1111; sif.b = 32'h0; sif.in_valid = 1'b1;
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    k = 1;
    wait_done(k);
    chk("bp latency", k, 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", {31'b0, sif.out_valid}, 32'd1);
      chk("bp in_ready",  {31'b0, sif.in_ready},  32'd0);
      chk("bp diff",      sif.diff,               32'h0009_FFFF);
      chk("bp borrow",    {31'b0, sif.borrow_out}, 32'd0);
      @(posedge clk); #1;
    end
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.out_ready = 1'b0;
    chk("bp delivered", {31'b0, sif.out_valid}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("bp no second result", {31'b0, sif.out_valid}, 32'd0);
    chk("bp idle in_ready",    {31'b0, sif.in_ready},  32'd1);

    // Reset in the middle of BUSY (chunk index 2)
    @(negedge clk);
    sif.a = 32'hFFFF_FFFF; sif.b = 32'h0101_0101; sif.borrow_in = 1'b0; sif.in_valid = 1'b1;
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {31'b0, sif.out_valid}, 32'd0);
    chk("midrst diff",      sif.diff,               32'd0);
    chk("midrst in_ready",  {31'b0, sif.in_ready},  32'd1);
    chk("midrst borrow",    {31'b0, sif.borrow_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op(32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0, "9-4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
